// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_e;

  typedef enum logic [1:0] {
    P_NONE,
    P_I,
    P_D
  } port_e;

  // The raw size code 11 behaves like a full word.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   decode_size = SZ_B;
      2'b01:   decode_size = SZ_H;
      default: decode_size = SZ_W;
    endcase
  endfunction

  // Splice right-justified store data into the word read back from memory.
  function automatic logic [31:0] merge_sub(input logic [31:0] rdata,
                                            input logic [31:0] wdata,
                                            input size_e       size);
    case (size)
      SZ_B:    merge_sub = {rdata[31:8], wdata[7:0]};
      SZ_H:    merge_sub = {rdata[31:16], wdata[15:0]};
      default: merge_sub = wdata;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: round-robin on ties, or fixed data-port priority.
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_fetch,
  input  logic req_data,
  output logic gnt_fetch,
  output logic gnt_data
);

  logic last_data;

  // Same-cycle grant; on a tie round-robin favours the port not served last.
  always_comb begin
    gnt_fetch = 1'b0;
    gnt_data  = 1'b0;
    if (en) begin
      if (req_fetch && req_data) begin
        if (RR_EN && last_data) begin
          gnt_fetch = 1'b1;
        end else begin
          gnt_data = 1'b1;
        end
      end else begin
        gnt_fetch = req_fetch;
        gnt_data  = req_data;
      end
    end
  end

  // History of the most recent grant; starts as "fetch" so the first tie goes to data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data <= 1'b0;
    end else if (gnt_data) begin
      last_data <= 1'b1;
    end else if (gnt_fetch) begin
      last_data <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port Memoria32 between a fetch port and a load/store port;
// sub-word stores are turned into a read followed by a merged full-word write.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_n,
  input  logic [31:0] mem_rdata
);

  state_e      state;
  port_e       owner;
  size_e       req_size;
  size_e       lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] last_addr;
  logic        sub_store;

  assign req_size  = decode_size(d_size);
  assign sub_store = d_we && (req_size != SZ_W);

  rr_arb2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .en       (state == IDLE),
    .req_fetch(i_req),
    .req_data (d_req),
    .gnt_fetch(i_gnt),
    .gnt_data (d_gnt)
  );

  // Memory port: merged write in RMW_WR, otherwise the winner's address, else hold.
  always_comb begin
    mem_addr  = last_addr;
    mem_wdata = '0;
    mem_wr_n  = 1'b1;
    if (state == RMW_WR) begin
      mem_addr  = lat_addr;
      mem_wr_n  = 1'b0;
      mem_wdata = merge_sub(mem_rdata, lat_wdata, lat_size);
    end else if (d_gnt) begin
      mem_addr = d_addr;
      if (d_we && !sub_store) begin
        mem_wr_n  = 1'b0;
        mem_wdata = d_wdata;
      end
    end else if (i_gnt) begin
      mem_addr = i_addr;
    end
  end

  // Read data is steered to whichever port owned the read issued last cycle.
  always_comb begin
    i_rvalid = (owner == P_I);
    d_rvalid = (owner == P_D);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

  // Sequencer: read ownership, held address, and the IDLE/RMW_WR state machine.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      owner     <= P_NONE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= SZ_B;
      last_addr <= '0;
    end else begin
      last_addr <= mem_addr;
      if (d_gnt && !d_we) begin
        owner <= P_D;
      end else if (i_gnt) begin
        owner <= P_I;
      end else begin
        owner <= P_NONE;
      end
      case (state)
        IDLE: begin
          if (d_gnt && sub_store) begin
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_size  <= req_size;
            state     <= RMW_WR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a byte-addressed Memoria32 model plus a transaction-level
// reference memory that predicts grants, write strobes and returned data.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_wr_n;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        fp_i_gnt, fp_i_rvalid, fp_d_gnt, fp_d_rvalid, fp_mem_wr_n;
  logic [31:0] fp_i_rdata, fp_d_rdata, fp_mem_addr, fp_mem_wdata;
  logic [31:0] zero_word = '0;

  int n_compared = 0;
  int n_mismatched = 0;

  // Memory model contents and the bench's own expected contents.
  logic [7:0]  mem_bytes [256];
  logic [7:0]  ref_mem   [256];
  logic [7:0]  ref_save  [256];
  bit          mem_loaded = 1'b0;

  // Reference state kept at transaction level.
  bit          last_was_d;
  bit          busy;
  bit          hold_reqs;
  bit          pend_i, pend_d;
  logic [31:0] exp_i_data, exp_d_data;
  logic [31:0] lat_addr, ref_addr;
  logic [31:0] last_d_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_EN(1'b1)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_n(mem_wr_n), .mem_rdata(mem_rdata)
  );

  // Fixed-priority instance shares the request inputs; only its grants are checked.
  mem_port_arbiter #(.RR_EN(1'b0)) dut_fixed (
    .Clk(clk), .Rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(fp_i_gnt), .i_rvalid(fp_i_rvalid), .i_rdata(fp_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(fp_d_gnt), .d_rvalid(fp_d_rvalid), .d_rdata(fp_d_rdata),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wr_n(fp_mem_wr_n), .mem_rdata(zero_word)
  );

  function automatic logic [7:0] bidx(input logic [31:0] a, input int k);
    return 8'(a + 32'(k));
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[bidx(a, 3)], ref_mem[bidx(a, 2)], ref_mem[bidx(a, 1)], ref_mem[bidx(a, 0)]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_bytes[bidx(a, 3)], mem_bytes[bidx(a, 2)], mem_bytes[bidx(a, 1)], mem_bytes[bidx(a, 0)]};
  endfunction

  // Memoria32 behaviour: registered 32-bit read and 32-bit write at any byte address.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      mem_loaded <= 1'b1;
      for (int k = 0; k < 256; k++) mem_bytes[k] <= ref_mem[k];
    end else begin
      mem_rdata <= mem_word(mem_addr);
      if (!mem_wr_n) begin
        mem_bytes[bidx(mem_addr, 0)] <= mem_wdata[7:0];
        mem_bytes[bidx(mem_addr, 1)] <= mem_wdata[15:8];
        mem_bytes[bidx(mem_addr, 2)] <= mem_wdata[23:16];
        mem_bytes[bidx(mem_addr, 3)] <= mem_wdata[31:24];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: predict, check mid-cycle, update the model, advance past the edge.
  task automatic applyStimulus();
    bit          e_i, e_d, e_wr, clr_i, clr_d, nxt_pi, nxt_pd, nxt_busy;
    logic [31:0] e_addr, e_wdata;
    int          n_bytes;
    n_bytes = (d_size == 2'b00) ? 1 : (d_size == 2'b01) ? 2 : 4;
    e_i = 1'b0;
    e_d = 1'b0;
    if (!busy) begin
      if (i_req && d_req) begin
        e_d = !last_was_d;
        e_i = last_was_d;
      end else begin
        e_i = i_req;
        e_d = d_req;
      end
    end
    e_wr = 1'b0;
    e_addr = ref_addr;
    e_wdata = '0;
    if (busy) begin
      e_addr = lat_addr;
      e_wr = 1'b1;
      e_wdata = ref_word(lat_addr);
    end else if (e_d) begin
      e_addr = d_addr;
      if (d_we && n_bytes == 4) begin
        e_wr = 1'b1;
        e_wdata = d_wdata;
      end
    end else if (e_i) begin
      e_addr = i_addr;
    end
    #4;
    checkOutput("i_gnt", 32'(i_gnt), 32'(e_i));
    checkOutput("d_gnt", 32'(d_gnt), 32'(e_d));
    checkOutput("mem_wr_n", 32'(mem_wr_n), 32'(!e_wr));
    checkOutput("mem_addr", mem_addr, e_addr);
    if (e_wr) checkOutput("mem_wdata", mem_wdata, e_wdata);
    checkOutput("i_rvalid", 32'(i_rvalid), 32'(pend_i));
    checkOutput("d_rvalid", 32'(d_rvalid), 32'(pend_d));
    if (pend_i) checkOutput("i_rdata", i_rdata, exp_i_data);
    if (pend_d) begin
      checkOutput("d_rdata", d_rdata, exp_d_data);
      last_d_rdata = d_rdata;
    end
    nxt_pi = 1'b0;
    nxt_pd = 1'b0;
    nxt_busy = 1'b0;
    clr_i = 1'b0;
    clr_d = 1'b0;
    if (e_d) begin
      last_was_d = 1'b1;
      clr_d = !hold_reqs;
      if (d_we) begin
        for (int k = 0; k < n_bytes; k++) ref_mem[bidx(d_addr, k)] = d_wdata[8*k +: 8];
        if (n_bytes < 4) begin
          nxt_busy = 1'b1;
          lat_addr = d_addr;
        end
      end else begin
        nxt_pd = 1'b1;
        exp_d_data = ref_word(d_addr);
      end
    end
    if (e_i) begin
      last_was_d = 1'b0;
      clr_i = !hold_reqs;
      nxt_pi = 1'b1;
      exp_i_data = ref_word(i_addr);
    end
    busy = nxt_busy;
    pend_i = nxt_pi;
    pend_d = nxt_pd;
    ref_addr = e_addr;
    @(posedge clk);
    #1;
    if (clr_i) i_req = 1'b0;
    if (clr_d) d_req = 1'b0;
  endtask

  task automatic resetModel();
    last_was_d = 1'b0;
    busy = 1'b0;
    pend_i = 1'b0;
    pend_d = 1'b0;
    ref_addr = '0;
    lat_addr = '0;
  endtask

  // Directed scenarios followed by a randomized traffic phase.
  initial begin
    logic [7:0] orig45, orig46;
    int bad;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b10; d_addr = '0; d_wdata = '0;
    hold_reqs = 1'b0;
    last_d_rdata = '0;
    exp_i_data = '0;
    exp_d_data = '0;
    resetModel();
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'($urandom);
    ref_mem[8'h40] = 8'h44; ref_mem[8'h41] = 8'h33; ref_mem[8'h42] = 8'h22; ref_mem[8'h43] = 8'h11;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_i_gnt", 32'(i_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("rst_i_rdata", i_rdata, 32'd0);
    checkOutput("rst_d_rdata", d_rdata, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_wr_n", 32'(mem_wr_n), 32'd1);
    rst_n = 1'b1;

    $display("[TB] tie on the first cycle after reset");
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h10;
    repeat (3) applyStimulus();

    $display("[TB] unaligned word store then load");
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h21; d_wdata = 32'hDEADBEEF;
    applyStimulus();
    d_req = 1'b1; d_we = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("word_reload", last_d_rdata, 32'hDEADBEEF);

    $display("[TB] byte store read-modify-write");
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h40; d_wdata = 32'h123456AA;
    applyStimulus();
    i_req = 1'b1; i_addr = 32'h84;
    repeat (2) applyStimulus();
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h40;
    repeat (2) applyStimulus();
    checkOutput("byte_reload", last_d_rdata, 32'h112233AA);

    $display("[TB] unaligned half store");
    orig45 = ref_mem[8'h45];
    orig46 = ref_mem[8'h46];
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = 32'h43; d_wdata = 32'h7777BEEF;
    repeat (3) applyStimulus();
    checkOutput("half_b43", 32'(mem_bytes[8'h43]), 32'hEF);
    checkOutput("half_b44", 32'(mem_bytes[8'h44]), 32'hBE);
    checkOutput("half_b45", 32'(mem_bytes[8'h45]), 32'(orig45));
    checkOutput("half_b46", 32'(mem_bytes[8'h46]), 32'(orig46));

    $display("[TB] continuous requests on both ports");
    hold_reqs = 1'b1;
    i_req = 1'b1; i_addr = 32'h88;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h14;
    for (int c = 0; c < 10; c++) begin
      applyStimulus();
      checkOutput("fixed_d_gnt", 32'(fp_d_gnt), 32'd1);
      checkOutput("fixed_i_gnt", 32'(fp_i_gnt), 32'd0);
    end
    hold_reqs = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    applyStimulus();

    $display("[TB] reset during the write half of a read-modify-write");
    ref_save = ref_mem;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h60; d_wdata = 32'h00000055;
    applyStimulus();
    checkOutput("rmw_wr_n", 32'(mem_wr_n), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_wr_n", 32'(mem_wr_n), 32'd1);
    checkOutput("rst_mid_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d_req = 1'b0;
    ref_mem = ref_save;
    resetModel();
    repeat (2) applyStimulus();
    checkOutput("rst_mid_word", mem_word(32'h60), ref_word(32'h60));

    $display("[TB] randomized traffic");
    for (int c = 0; c < 300; c++) begin
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_size = 2'($urandom_range(0, 3));
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      applyStimulus();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) applyStimulus();
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem_bytes[k] !== ref_mem[k]) bad++;
    checkOutput("mem_image", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer in front of the single-port, byte-banked `Memoria32` memory. It shares the memory between an instruction-fetch port (read-only) and a data port (read/write, byte/half/word). Sub-word stores become a 2-cycle read-modify-write, because `Memoria32` always writes 32 bits at the byte address given. It sits between the core's fetch and load/store units and the `Memoria32` instance.

## Interface
- `RR_EN`, default 1. 1 selects round-robin on ties; 0 selects fixed priority, D-port always wins.
- `Clk` input 1: the only clock; everything is rising-edge.
- `Rst_n` input 1: asynchronous, active-low reset.
- `i_req` input 1: fetch request; held, with `i_addr`, until `i_gnt`.
- `i_addr` input 32: fetch byte address.
- `i_gnt` output 1: fetch request accepted this cycle.
- `i_rvalid` output 1: `i_rdata` valid this cycle.
- `i_rdata` output 32: fetch data.
- `d_req` input 1: data request; held with all `d_*` inputs until `d_gnt`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_size` input 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `d_addr` input 32: data byte address; any alignment is legal.
- `d_wdata` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `d_gnt` output 1: data request accepted this cycle.
- `d_rvalid` output 1: `d_rdata` valid this cycle; asserted for loads only.
- `d_rdata` output 32: the 32-bit word starting at `d_addr`; extension is done by the requester.
- `mem_addr` output 32: drives the `Memoria32` address (read and write address are the same).
- `mem_wdata` output 32: drives `Datain`.
- `mem_wr_n` output 1: active-low write strobe to `Wr`.
- `mem_rdata` input 32: from `Dataout`; valid one cycle after the address is presented.

## Operation
- States: IDLE and RMW_WR.
- **IDLE:**
  - Arbitrate `i_req` and `d_req`. The winner gets its `*_gnt` combinationally in the same cycle, and `mem_addr` = winner's address.
  - With `RR_EN`=1 and both requesting, grant the port not granted last. `last_gnt` resets to the I-port, so the first tie goes to the D-port.
- **Load or fetch grant:**
  - `mem_wr_n`=1.
  - Register the owner (I or D). In the next cycle assert that owner's `*_rvalid` with `*_rdata` = `mem_rdata`.
  - Stay in IDLE, so back-to-back reads run at one per cycle.
- **Word store grant:**
  - `mem_wr_n`=0 and `mem_wdata`=`d_wdata` in the grant cycle.
  - Stay in IDLE; no rvalid.
- **Byte/half store grant:**
  - Read the word at `d_addr` (`mem_wr_n`=1).
  - Latch `d_addr`, `d_size` and `d_wdata`; go to RMW_WR.
- **RMW_WR:**
  - `mem_addr` = latched address, `mem_wr_n`=0.
  - `mem_wdata` = `mem_rdata` with bits [7:0] (byte) or [15:0] (half) replaced by the latched data.
  - No grant is issued in this state; return to IDLE.
- Idle outputs: when no port is granted and the state is IDLE, `mem_addr` holds its last value and `mem_wr_n`=1.
- `*_rvalid` is never asserted for a store.
- A read granted in the cycle before RMW_WR still returns its data in RMW_WR; the read pipeline is independent of state.

## Timing
- **Reset values:** all `*_gnt`=0, `*_rvalid`=0, `*_rdata`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wr_n`=1; state=IDLE; owner=none; `last_gnt`=I.
- **Reset asserted mid-RMW:** `mem_wr_n` returns to 1 immediately (asynchronous). The pending write is dropped and any pending rvalid is cancelled.
- **Latency:**
  - Read: grant at cycle N, rvalid at N+1.
  - Word store: occupies 1 cycle.
  - Sub-word store: occupies 2 cycles; the next grant is possible at N+2.
- **Request during RMW_WR:** the request waits. It is arbitrated on return to IDLE, with round-robin history already updated by the store's grant.
- **Address wrap:** addresses pass through unmodified; wrap-around is handled by `Memoria32`.

## Structure
- Package `mem_arb_pkg` contains:
  - `size_e` (`SZ_B`, `SZ_H`, `SZ_W`)
  - `state_e` (`IDLE`, `RMW_WR`)
  - `port_e` (`P_NONE`, `P_I`, `P_D`)
  - the function `merge_sub(rdata, wdata, size)`
- Sub-module `rr_arb2`: a two-requester round-robin arbiter with `last_gnt` register, enable input (from the state), and `RR_EN` parameter.

## Test plan
- **Tie on first cycle:** `i_req`, `d_req` (load, addr 0x10) both high at the first cycle after reset → `d_gnt` first, then `i_gnt` the next cycle; rvalids at +1 each with memory contents.
- **Word store then load:** store 0xDEADBEEF to 0x21 (unaligned), then load word at 0x21 → `d_rdata`=0xDEADBEEF; `mem_wr_n` low for exactly 1 cycle.
- **Byte store RMW:** with the word at 0x40 = 0x11223344, store byte 0xAA to 0x40 → 2-cycle busy, `i_gnt` held off in RMW_WR, reload gives 0x112233AA.
- **Half store RMW, unaligned:** half store 0xBEEF to 0x43 → bytes 0x43/0x44 = EF/BE; bytes 0x45 and 0x46 unchanged.
- **Continuous requests, round-robin:** `i_req` and `d_req` held high for 10 cycles, `RR_EN`=1 → strictly alternating grants. With `RR_EN`=0 → `d_gnt` every cycle and `i_gnt` never.
- **Reset mid-RMW:** `Rst_n` pulsed low during RMW_WR → `mem_wr_n` goes to 1 within the same cycle, memory word unchanged, no rvalid after reset.
